// File: rtl/phase_offset_nco_pkg.sv
// Shared constants, state encoding and step clamp for the phase-offset NCO.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package phase_offset_nco_pkg;

  // Phase units are 1/512 rad, so pi is 1608 units.
  localparam int PHASE_W = 32;
  localparam int PI_VAL  = 1608;
  localparam int TWO_PI  = 2 * PI_VAL;

  // The largest and smallest step that the NCO will accept.
  localparam logic signed [PHASE_W-1:0] STEP_MAX = PHASE_W'(PI_VAL - 1);
  localparam logic signed [PHASE_W-1:0] STEP_MIN = PHASE_W'(-PI_VAL);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } nco_state_e;

  // Limit a requested step to [-pi, pi-1]. This bound means a single wrap
  // correction is always enough in the accumulator.
  function automatic logic [PHASE_W-1:0] clamp_step(input logic signed [PHASE_W-1:0] x);
    logic [PHASE_W-1:0] r;
    if (x > STEP_MAX) begin
      r = STEP_MAX;
    end else if (x < STEP_MIN) begin
      r = STEP_MIN;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_offset_nco_phase_wrap_add.sv
// Signed phase add with a single wrap into [-pi, pi).
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs directly.
module phase_wrap_add
  import phase_offset_nco_pkg::*;
(
  input  logic [PHASE_W-1:0] a_i,
  input  logic [PHASE_W-1:0] b_i,
  output logic [PHASE_W-1:0] sum_o
);

  localparam logic signed [PHASE_W:0] PI_33     = (PHASE_W+1)'(PI_VAL);
  localparam logic signed [PHASE_W:0] TWO_PI_33 = (PHASE_W+1)'(TWO_PI);

  logic signed [PHASE_W:0] sum_raw;
  logic signed [PHASE_W:0] sum_wrapped;

  // Sign-extended add, then fold back into one period.
  always_comb begin
    sum_raw = $signed({a_i[PHASE_W-1], a_i}) + $signed({b_i[PHASE_W-1], b_i});
    if (sum_raw >= PI_33) begin
      sum_wrapped = sum_raw - TWO_PI_33;
    end else if (sum_raw < -PI_33) begin
      sum_wrapped = sum_raw + TWO_PI_33;
    end else begin
      sum_wrapped = sum_raw;
    end
    sum_o = sum_wrapped[PHASE_W-1:0];
  end

endmodule

// File: rtl/phase_offset_nco.sv
// NCO that tags each sample with a wrapped CFO rotation angle after preamble lock.
// Latency: 1 cycle from sample_in_strobe to sample_out_strobe.
// Backpressure: none. Macro PHASE_NCO_RELOCK_EN lets a detect re-lock while LOCKED.
module phase_offset_nco
  import phase_offset_nco_pkg::*;
#(
  parameter logic [31:0] MAX_SAMPLES = 32'd65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] sample_in,
  input  logic        sample_in_strobe,
  input  logic        short_preamble_detected,
  input  logic [31:0] phase_offset,
  input  logic        clear,
  output logic [31:0] sample_out,
  output logic        sample_out_strobe,
  output logic [31:0] phase_out,
  output logic        locked
);

  nco_state_e         state_q, state_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        sout_q, sout_d;
  logic               sstb_q, sstb_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  logic [PHASE_W-1:0] acc_next;
  logic               detect_ok;
  logic               timeout_hit;

  phase_wrap_add u_wrap (
    .a_i   (acc_q),
    .b_i   (step_q),
    .sum_o (acc_next)
  );

`ifdef PHASE_NCO_RELOCK_EN
  assign detect_ok = short_preamble_detected;
`else
  assign detect_ok = short_preamble_detected && (state_q == IDLE);
`endif

  // The last sample before timeout is still tagged with its phase.
  assign timeout_hit = (MAX_SAMPLES != 32'd0) && (cnt_q == MAX_SAMPLES - 32'd1);

  // Next-state: output capture first, then clear > detect > accumulate.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    phase_d = phase_q;
    sstb_d  = 1'b0;

    // A sample always leaves with the pre-update phase (0 outside LOCKED).
    if (sample_in_strobe) begin
      sstb_d  = 1'b1;
      sout_d  = sample_in;
      phase_d = (state_q == LOCKED) ? acc_q : '0;
    end

    if (clear) begin
      state_d = IDLE;
      step_d  = '0;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (detect_ok) begin
      state_d = LOCKED;
      step_d  = clamp_step(phase_offset);
      acc_d   = '0;
      cnt_d   = '0;
    end else if ((state_q == LOCKED) && sample_in_strobe) begin
      if (timeout_hit) begin
        state_d = IDLE;
        step_d  = '0;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // State register; enable low freezes everything except the output strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sout_q  <= '0;
      sstb_q  <= 1'b0;
      phase_q <= '0;
    end else if (enable) begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      sstb_q  <= sstb_d;
      phase_q <= phase_d;
    end else begin
      sstb_q <= 1'b0;
    end
  end

  assign sample_out        = sout_q;
  assign sample_out_strobe = sstb_q;
  assign phase_out         = phase_q;
  assign locked            = (state_q == LOCKED);

endmodule
